// File: rtl/cam_match_unit_pkg.sv
// Shared defaults and index-width helper for the CAM match unit.
package cam_match_unit_pkg;

    localparam int DEF_WIDTH = 8;
    localparam int DEF_DEPTH = 4;

    function automatic int clog2(input int n);
        int r;
        r = 0;
        for (int v = n - 1; v > 0; v = v >> 1) r++;
        return r;
    endfunction

endpackage

// File: rtl/cam_match_unit_if.sv
// Update/lookup request and match result bundle of the CAM match unit.
interface cam_match_unit_if
    import cam_match_unit_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int DEPTH = DEF_DEPTH,
    localparam int IDXW = clog2(DEPTH)
);
    logic             wr_en;
    logic [IDXW-1:0]  wr_idx;
    logic [WIDTH-1:0] wr_data;
    logic             inv_en;
    logic [IDXW-1:0]  inv_idx;
    logic             flush;
    logic             lk_valid;
    logic [WIDTH-1:0] lk_key;
    logic             out_valid;
    logic [DEPTH-1:0] match_vec;
    logic             hit;
    logic [IDXW-1:0]  hit_idx;
    logic             multi_hit;

    modport master (
        output wr_en, wr_idx, wr_data, inv_en, inv_idx, flush, lk_valid, lk_key,
        input  out_valid, match_vec, hit, hit_idx, multi_hit
    );

    modport slave (
        input  wr_en, wr_idx, wr_data, inv_en, inv_idx, flush, lk_valid, lk_key,
        output out_valid, match_vec, hit, hit_idx, multi_hit
    );
endinterface

// File: rtl/cam_match_unit_entry.sv
// One CAM entry: valid flop, tag register and valid-gated equality compare.
module cam_entry #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             set_valid,
    input  logic             clr_valid,
    input  logic [WIDTH-1:0] wr_data,
    input  logic [WIDTH-1:0] key,
    output logic             match
);
    logic             valid;
    logic [WIDTH-1:0] tag;

    // Set wins over clear so a write coinciding with flush/invalidate sticks.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid <= 1'b0;
        end else if (set_valid) begin
            valid <= 1'b1;
        end else if (clr_valid) begin
            valid <= 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (set_valid) tag <= wr_data;
    end

    assign match = valid & (&(~(tag ^ key)));
endmodule

// File: rtl/cam_match_unit.sv
// CAM match unit: DEPTH tagged entries, registered one-hot match, hit index and multi-hit.
module cam_match_unit
    import cam_match_unit_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int DEPTH = DEF_DEPTH,
    localparam int IDXW = clog2(DEPTH)
) (
    input logic              clk,
    input logic              rst,
    cam_match_unit_if.slave  bus
);
    logic [DEPTH-1:0] match_c;
    logic [IDXW-1:0]  idx_c;
    logic             hit_c;
    logic             multi_c;

    logic             out_valid_q;
    logic [DEPTH-1:0] match_q;
    logic             hit_q;
    logic [IDXW-1:0]  idx_q;
    logic             multi_q;

    for (genvar i = 0; i < DEPTH; i++) begin : g_entry
        logic set_i;
        logic clr_i;

        assign set_i = bus.wr_en && (bus.wr_idx == IDXW'(i));
        assign clr_i = bus.flush || (bus.inv_en && (bus.inv_idx == IDXW'(i)));

        cam_entry #(.WIDTH(WIDTH)) u_entry (
            .clk       (clk),
            .rst       (rst),
            .set_valid (set_i),
            .clr_valid (clr_i),
            .wr_data   (bus.wr_data),
            .key       (bus.lk_key),
            .match     (match_c[i])
        );
    end

    // Scan downward so the lowest matching index is the last assignment.
    always_comb begin
        idx_c = '0;
        for (int i = DEPTH - 1; i >= 0; i--) begin
            if (match_c[i]) idx_c = IDXW'(i);
        end
    end

    assign hit_c   = |match_c;
    assign multi_c = (match_c & (match_c - DEPTH'(1))) != '0;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid_q <= 1'b0;
            match_q     <= '0;
            hit_q       <= 1'b0;
            idx_q       <= '0;
            multi_q     <= 1'b0;
        end else if (bus.lk_valid) begin
            out_valid_q <= 1'b1;
            match_q     <= match_c;
            hit_q       <= hit_c;
            idx_q       <= idx_c;
            multi_q     <= multi_c;
        end else begin
            out_valid_q <= 1'b0;
            match_q     <= '0;
            hit_q       <= 1'b0;
            idx_q       <= '0;
            multi_q     <= 1'b0;
        end
    end

    assign bus.out_valid = out_valid_q;
    assign bus.match_vec = match_q;
    assign bus.hit       = hit_q;
    assign bus.hit_idx   = idx_q;
    assign bus.multi_hit = multi_q;
endmodule
